dist_fetch_unit: RTL and testbench

DIST_FETCH_UNIT -- requirements
Module: dist_fetch_unit

---
 rtl/dist_pkg.sv | 23 ++
 rtl/dist_word_reader.sv | 55 +++++
 rtl/dist_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_dist_fetch_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
// Shared definitions for distribution fetch: state encodings, default
// geometry constants and the word address offset helper.
package dist_pkg;

  localparam int DIST_WORD_W    = 32;
  localparam int DIST_NUM_WORDS = 8;
  localparam int DIST_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT     = 3'd2,
    ST_DATA_OUT = 3'd3,
    ST_ERROR    = 3'd4
  } dist_state_t;

  // Byte offset of word idx; one word spans WORD_W/32 32-bit lanes.
  function automatic logic [31:0] dist_word_offset(input logic [31:0] idx,
                                                   input int          word_w);
    return idx * 32'(4 * (word_w / 32));
  endfunction

endpackage

// File: rtl/dist_word_reader.sv
// Single-word read handshake: raises mem_req for the issue and wait
// cycles, holds the address captured at issue, qualifies acks and
// flags a timeout when the wait runs TIMEOUT cycles without an ack.
module dist_word_reader
  import dist_pkg::*;
#(
  parameter int TIMEOUT = DIST_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_issue,
  input  logic        i_wait,
  input  logic [31:0] i_addr,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        o_ack,
  output logic        o_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo;
  logic [31:0]   r_addr;
  logic          w_tmo_last;

  // An ack only counts once the request has been visible for a full
  // cycle, so an ack coinciding with the issue cycle is dropped.
  assign mem_req    = i_issue | i_wait;
  assign mem_addr   = i_issue ? i_addr : (i_wait ? r_addr : 32'h0);
  assign o_ack      = i_wait & mem_ack;
  assign w_tmo_last = (r_tmo == TW'(TIMEOUT - 1));
  assign o_timeout  = i_wait & ~mem_ack & w_tmo_last;

  // Capture the request address at issue so it stays put while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= 32'h0;
    end else if (i_issue) begin
      r_addr <= i_addr;
    end
  end

  // Wait-cycle counter, restarted on every issue (the only way into WAIT).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (i_issue) begin
      r_tmo <= '0;
    end else if (i_wait && !mem_ack && !w_tmo_last) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

endmodule

// File: rtl/dist_fetch_unit.sv
// Distribution fetch unit: on a decode request, reads NUM_WORDS words
// starting at rs1, assembles them into a buffer and publishes the whole
// distribution at once with a one-cycle valid, stalling the pipeline
// for the duration. A word that never acks aborts the fetch with a
// sticky error.
module dist_fetch_unit
  import dist_pkg::*;
#(
  parameter  int WORD_W    = DIST_WORD_W,
  parameter  int NUM_WORDS = DIST_NUM_WORDS,
  parameter  int TIMEOUT   = DIST_TIMEOUT,
  localparam int DIST_W    = WORD_W * NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DUCtrl,
  input  logic [31:0]       rs1,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [DIST_W-1:0] DU_result,
  output logic              du_valid,
  output logic              du_clk_stall,
  output logic              du_error
);

  localparam int            CW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  generate
    if ((WORD_W < 32) || ((WORD_W % 32) != 0)) begin : g_bad_word_w
      $error("dist_fetch_unit: WORD_W must be a non-zero multiple of 32");
    end
    if (NUM_WORDS < 1) begin : g_bad_num_words
      $error("dist_fetch_unit: NUM_WORDS must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("dist_fetch_unit: TIMEOUT must be at least 1");
    end
  endgenerate

  dist_state_t       r_state;
  dist_state_t       w_next;
  logic [31:0]       r_base;
  logic [CW-1:0]     r_cnt;
  logic [DIST_W-1:0] r_buf;
  logic [DIST_W-1:0] w_buf_next;
  logic [DIST_W-1:0] r_result;
  logic              r_valid;
  logic              r_error;
  logic              w_accept;
  logic              w_is_last;
  logic              w_issue;
  logic              w_wait;
  logic              w_ack;
  logic              w_timeout;
  logic              w_stall;
  logic [31:0]       w_addr;

  assign w_issue   = (r_state == ST_REQ);
  assign w_wait    = (r_state == ST_WAIT);
  assign w_accept  = (r_state == ST_IDLE) && DUCtrl;
  assign w_is_last = (r_cnt == LAST);
  assign w_addr    = r_base + dist_word_offset(32'(r_cnt), WORD_W);

  dist_word_reader #(
    .TIMEOUT (TIMEOUT)
  ) u_reader (
    .clk       (clk),
    .rst       (rst),
    .i_issue   (w_issue),
    .i_wait    (w_wait),
    .i_addr    (w_addr),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .o_ack     (w_ack),
    .o_timeout (w_timeout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE. DUCtrl is
  // only looked at in IDLE, so requests during a fetch are dropped.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:     w_next = DUCtrl ? ST_REQ : ST_IDLE;
      ST_REQ:      w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_ack) begin
          w_next = w_is_last ? ST_DATA_OUT : ST_REQ;
        end else if (w_timeout) begin
          w_next = ST_ERROR;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_DATA_OUT: w_next = ST_IDLE;
      ST_ERROR:    w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Stall covers the whole fetch including the accepting IDLE cycle.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_REQ, ST_WAIT, ST_DATA_OUT, ST_ERROR: w_stall = 1'b1;
      ST_IDLE:                                w_stall = DUCtrl;
      default:                                w_stall = 1'b0;
    endcase
  end

  // Buffer image including the word being acked this cycle.
  always_comb begin
    w_buf_next = r_buf;
    if (w_ack) begin
      w_buf_next[r_cnt*WORD_W +: WORD_W] = mem_rdata;
    end
  end

  // Fetch bookkeeping: base/counter, word buffer and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base  <= 32'h0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base  <= rs1;
        r_cnt   <= '0;
        r_error <= 1'b0;
      end
      if (w_ack) begin
        r_buf <= w_buf_next;
        if (!w_is_last) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  // Result and valid are loaded on the edge into DATA_OUT so the full
  // distribution and its pulse appear together, only in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_ack && w_is_last) begin
        r_result <= w_buf_next;
        r_valid  <= 1'b1;
      end
    end
  end

  assign DU_result    = r_result;
  assign du_valid     = r_valid;
  assign du_error     = r_error;
  assign du_clk_stall = w_stall & ~rst;

endmodule

// File: tb/tb_dist_fetch_unit.sv
// Directed bench for dist_fetch_unit: default geometry instance plus a
// single 64-bit-word instance. The bench plays the memory.
module tb_dist_fetch_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         DUCtrl;
  logic [31:0]  rs1;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic [255:0] DU_result;
  logic         du_valid;
  logic         du_clk_stall;
  logic         du_error;

  logic         w_DUCtrl;
  logic [31:0]  w_rs1;
  logic         w_mem_req;
  logic [31:0]  w_mem_addr;
  logic         w_mem_ack;
  logic [63:0]  w_mem_rdata;
  logic [63:0]  w_DU_result;
  logic         w_du_valid;
  logic         w_du_clk_stall;
  logic         w_du_error;

  int checks = 0;
  int errors = 0;

  // observations recorded by run_fetch
  logic [31:0]  obs_addr [0:15];
  int           obs_n;
  int           valid_cyc;
  int           valid_cnt;
  int           err_cyc;
  bit           stall_ok;
  bit           addr_unstable;
  logic         stall0;
  logic         stall_after;
  logic         err_at1;
  bit           rst_seen;
  logic         snap_req, snap_valid, snap_stall, snap_err;
  logic [31:0]  snap_addr;
  logic [255:0] snap_res;

  always #5 clk = ~clk;

  dist_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .DUCtrl       (DUCtrl),
    .rs1          (rs1),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .DU_result    (DU_result),
    .du_valid     (du_valid),
    .du_clk_stall (du_clk_stall),
    .du_error     (du_error)
  );

  dist_fetch_unit #(.WORD_W(64), .NUM_WORDS(1), .TIMEOUT(255)) dut_w (
    .clk          (clk),
    .rst          (rst),
    .DUCtrl       (w_DUCtrl),
    .rs1          (w_rs1),
    .mem_req      (w_mem_req),
    .mem_addr     (w_mem_addr),
    .mem_ack      (w_mem_ack),
    .mem_rdata    (w_mem_rdata),
    .DU_result    (w_DU_result),
    .du_valid     (w_du_valid),
    .du_clk_stall (w_du_clk_stall),
    .du_error     (w_du_error)
  );

  function automatic logic [255:0] exp_res(input logic [31:0] seed);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = seed + 32'(i);
    return r;
  endfunction

  // Runs one fetch on the default instance, acting as memory. Cycle 0 is
  // the accepting IDLE cycle. Word w is acked on its (1+delay)-th cycle
  // after the request appears, with data seed+w; miss_word never acks.
  task automatic run_fetch(input logic [31:0] base, input int delay,
                           input int miss_word, input bit req_ack,
                           input int pulse_a, input int pulse_b,
                           input int rst_word, input int max_cyc,
                           input logic [31:0] seed);
    int cyc, age, widx, tail;
    bit acked, prev_req;
    logic [31:0] prev_addr;
    obs_n = 0; valid_cyc = -1; valid_cnt = 0; err_cyc = -1;
    stall_ok = 1; addr_unstable = 0; stall_after = 1'bx; err_at1 = 1'bx;
    rst_seen = 0;
    rs1 = base; DUCtrl = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    #1 stall0 = du_clk_stall;
    cyc = 0; widx = -1; age = 0; acked = 1; prev_req = 0; prev_addr = '0;
    tail = -1;
    while (cyc < max_cyc && tail != 0) begin
      @(posedge clk); #1;
      cyc++;
      if (rst) rst = 1'b0;
      DUCtrl = (cyc == pulse_a) || (cyc == pulse_b);
      if (cyc == 1) err_at1 = du_error;
      if (mem_req && (!prev_req || mem_addr != prev_addr)) begin
        if (!acked) addr_unstable = 1;
        widx++;
        if (obs_n < 16) obs_addr[obs_n] = mem_addr;
        obs_n++;
        age = 0; acked = 0;
      end else if (mem_req) begin
        age++;
      end
      prev_req = mem_req; prev_addr = mem_addr;
      mem_ack = 1'b0; mem_rdata = '0;
      if (mem_req && age == 0 && req_ack) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      end
      if (mem_req && age == 1 + delay && widx != miss_word) begin
        mem_ack = 1'b1; mem_rdata = seed + 32'(widx); acked = 1;
      end
      if (mem_req && widx == rst_word && age == 1 && !rst_seen) begin
        mem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        snap_req = mem_req; snap_addr = mem_addr; snap_valid = du_valid;
        snap_stall = du_clk_stall; snap_err = du_error; snap_res = DU_result;
        rst_seen = 1;
      end
      #1;
      if (du_valid) begin
        valid_cnt++;
        if (valid_cyc < 0) valid_cyc = cyc;
      end
      if (du_error && err_cyc < 0) err_cyc = cyc;
      if (valid_cyc < 0 && err_cyc < 0 && !rst_seen && !du_clk_stall) stall_ok = 0;
      if (valid_cyc >= 0 && cyc == valid_cyc + 1) stall_after = du_clk_stall;
      if (tail > 0) tail--;
      else if (tail < 0 && (valid_cyc >= 0 || err_cyc >= 0 || rst_seen)) tail = 3;
    end
    DUCtrl = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; DUCtrl = 1'b1; rs1 = 32'h1234; mem_ack = 1'b1; mem_rdata = '1;
    w_DUCtrl = 1'b0; w_rs1 = '0; w_mem_ack = 1'b0; w_mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, du_valid, du_clk_stall, du_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got req/valid/stall/err=%b want 0000",
               {mem_req, du_valid, du_clk_stall, du_error});
    end
    checks++;
    if (mem_addr !== 32'h0 || DU_result !== 256'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h result=%h want 0", mem_addr, DU_result);
    end
    checks++;
    if ({w_mem_req, w_du_valid, w_du_clk_stall, w_DU_result} !== 67'h0) begin
      errors++;
      $display("FAIL reset_wide got nonzero outputs want 0");
    end
    DUCtrl = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int bad;
    run_fetch(32'h1000, 0, -1, 0, -1, -1, -1, 100, 32'h0);
    checks++;
    if (stall0 !== 1'b1) begin
      errors++; $display("FAIL basic_accept_stall got %b want 1", stall0);
    end
    checks++;
    if (valid_cyc !== 17 || valid_cnt !== 1) begin
      errors++;
      $display("FAIL basic_latency got cycle %0d count %0d want 17 1", valid_cyc, valid_cnt);
    end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (i >= obs_n || obs_addr[i] !== 32'h1000 + 32'(4*i)) bad++;
    checks++;
    if (obs_n !== 8 || bad != 0) begin
      errors++;
      $display("FAIL basic_addr got %0d requests %0d bad want 8 0", obs_n, bad);
    end
    checks++;
    if (DU_result !== exp_res(32'h0)) begin
      errors++;
      $display("FAIL basic_result got %h want %h", DU_result, exp_res(32'h0));
    end
    checks++;
    if (!stall_ok || stall_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_stall got held=%0d after=%b want 1 0", stall_ok, stall_after);
    end
  endtask

  task automatic test_wait_states;
    run_fetch(32'h2000, 3, -1, 0, -1, -1, -1, 200, 32'hA0000000);
    checks++;
    if (valid_cyc !== 41 || valid_cnt !== 1) begin
      errors++;
      $display("FAIL wait_latency got cycle %0d count %0d want 41 1", valid_cyc, valid_cnt);
    end
    checks++;
    if (addr_unstable || obs_n !== 8 || obs_addr[7] !== 32'h201C) begin
      errors++;
      $display("FAIL wait_addr got unstable=%0d n=%0d last=%h want 0 8 0000201c",
               addr_unstable, obs_n, obs_addr[7]);
    end
    checks++;
    if (!stall_ok || stall_after !== 1'b0) begin
      errors++;
      $display("FAIL wait_stall got held=%0d after=%b want 1 0", stall_ok, stall_after);
    end
    checks++;
    if (DU_result !== exp_res(32'hA0000000)) begin
      errors++;
      $display("FAIL wait_result got %h want %h", DU_result, exp_res(32'hA0000000));
    end
  endtask

  task automatic test_wrap;
    int bad;
    logic [31:0] a;
    run_fetch(32'hFFFFFFF8, 1, -1, 0, -1, -1, -1, 200, 32'h55000000);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      a = 32'hFFFFFFF8 + 32'(4*i);
      if (i >= obs_n || obs_addr[i] !== a) bad++;
    end
    checks++;
    if (obs_n !== 8 || bad != 0 || obs_addr[1] !== 32'hFFFFFFFC || obs_addr[2] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr got n=%0d bad=%0d a1=%h a2=%h want 8 0 fffffffc 00000000",
               obs_n, bad, obs_addr[1], obs_addr[2]);
    end
    checks++;
    if (valid_cyc !== 25 || DU_result !== exp_res(32'h55000000)) begin
      errors++;
      $display("FAIL wrap_result got cycle %0d result %h want 25 %h",
               valid_cyc, DU_result, exp_res(32'h55000000));
    end
  endtask

  task automatic test_req_ack_ignored;
    run_fetch(32'h3000, 0, -1, 1, -1, -1, -1, 100, 32'h77000000);
    checks++;
    if (valid_cyc !== 17 || DU_result !== exp_res(32'h77000000)) begin
      errors++;
      $display("FAIL req_ack_ignored got cycle %0d result %h want 17 %h",
               valid_cyc, DU_result, exp_res(32'h77000000));
    end
  endtask

  task automatic test_timeout;
    run_fetch(32'h4000, 0, 2, 0, -1, -1, -1, 400, 32'h11000000);
    checks++;
    if (err_cyc !== 261) begin
      errors++; $display("FAIL timeout_cycle got %0d want 261", err_cyc);
    end
    checks++;
    if (valid_cnt !== 0 || obs_n !== 3) begin
      errors++;
      $display("FAIL timeout_no_valid got valid=%0d requests=%0d want 0 3", valid_cnt, obs_n);
    end
    checks++;
    if (DU_result !== exp_res(32'h77000000) || du_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold got result %h err %b want %h 1",
               DU_result, du_error, exp_res(32'h77000000));
    end
    run_fetch(32'h4100, 0, -1, 0, -1, -1, -1, 100, 32'h99000000);
    checks++;
    if (err_at1 !== 1'b0 || du_error !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got %b want 0", err_at1);
    end
    checks++;
    if (valid_cyc !== 17 || DU_result !== exp_res(32'h99000000)) begin
      errors++;
      $display("FAIL timeout_recover got cycle %0d result %h want 17 %h",
               valid_cyc, DU_result, exp_res(32'h99000000));
    end
  endtask

  task automatic test_ignored_inputs;
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1; mem_rdata = 32'hBAD00000 + 32'(i);
      @(posedge clk); #1;
      if (mem_req !== 1'b0 || du_valid !== 1'b0 || du_clk_stall !== 1'b0) bad++;
    end
    mem_ack = 1'b0;
    checks++;
    if (bad != 0 || DU_result !== exp_res(32'h99000000)) begin
      errors++;
      $display("FAIL idle_ack got %0d bad cycles result %h want 0 %h",
               bad, DU_result, exp_res(32'h99000000));
    end
    run_fetch(32'h6000, 0, -1, 0, 5, 17, -1, 100, 32'h33000000);
    checks++;
    if (valid_cyc !== 17 || valid_cnt !== 1 || stall_after !== 1'b0) begin
      errors++;
      $display("FAIL busy_ductrl got cycle %0d count %0d after %b want 17 1 0",
               valid_cyc, valid_cnt, stall_after);
    end
    checks++;
    if (obs_n !== 8 || DU_result !== exp_res(32'h33000000)) begin
      errors++;
      $display("FAIL busy_result got n=%0d result %h want 8 %h",
               obs_n, DU_result, exp_res(32'h33000000));
    end
  endtask

  task automatic test_reset_mid;
    run_fetch(32'h5000, 2, -1, 0, -1, -1, 4, 200, 32'h44000000);
    checks++;
    if (!rst_seen || {snap_req, snap_valid, snap_stall, snap_err} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_ctrl got seen=%0d req/valid/stall/err=%b want 1 0000",
               rst_seen, {snap_req, snap_valid, snap_stall, snap_err});
    end
    checks++;
    if (snap_addr !== 32'h0 || snap_res !== 256'h0) begin
      errors++;
      $display("FAIL midrst_data got addr=%h result=%h want 0", snap_addr, snap_res);
    end
    checks++;
    if (valid_cnt !== 0 || DU_result !== 256'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after got valid=%0d result=%h req=%b want 0 0 0",
               valid_cnt, DU_result, mem_req);
    end
  endtask

  task automatic test_wide;
    w_rs1 = 32'h8000; w_DUCtrl = 1'b1; w_mem_ack = 1'b0;
    #1;
    checks++;
    if (w_du_clk_stall !== 1'b1) begin
      errors++; $display("FAIL wide_accept got stall %b want 1", w_du_clk_stall);
    end
    @(posedge clk); #1;
    w_DUCtrl = 1'b0;
    checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 32'h8000) begin
      errors++;
      $display("FAIL wide_req got req=%b addr=%h want 1 00008000", w_mem_req, w_mem_addr);
    end
    w_mem_ack = 1'b1; w_mem_rdata = 64'h1111111111111111;
    @(posedge clk); #1;
    w_mem_rdata = 64'h0123456789ABCDEF;
    checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 32'h8000 || w_du_valid !== 1'b0) begin
      errors++;
      $display("FAIL wide_wait got req=%b addr=%h valid=%b want 1 00008000 0",
               w_mem_req, w_mem_addr, w_du_valid);
    end
    @(posedge clk); #1;
    w_mem_ack = 1'b0;
    checks++;
    if (w_du_valid !== 1'b1 || w_DU_result !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL wide_result got valid=%b result=%h want 1 0123456789abcdef",
               w_du_valid, w_DU_result);
    end
    @(posedge clk); #1;
    checks++;
    if (w_du_valid !== 1'b0 || w_du_clk_stall !== 1'b0 || w_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL wide_done got valid=%b stall=%b req=%b want 0 0 0",
               w_du_valid, w_du_clk_stall, w_mem_req);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wait_states;
    test_wrap;
    test_req_ack_ignored;
    test_timeout;
    test_ignored_inputs;
    test_reset_mid;
    test_wide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
